// File: rtl/frame_scheduler_if.sv
// Signal bundle between the frame scheduler and the display timing / renderer side.
// The scheduler uses the slave view; the timing generator and renderer use the master view.
interface frame_scheduler_if;
    logic        vblank_start;
    logic        render_done;
    logic        lose;
    logic        btn;
    logic        swap;
    logic        front_buf;
    logic        game_rst;
    logic [15:0] frame_count;
    logic [7:0]  late_count;

    modport slave (
        input  vblank_start, render_done, lose, btn,
        output swap, front_buf, game_rst, frame_count, late_count
    );

    modport master (
        output vblank_start, render_done, lose, btn,
        input  swap, front_buf, game_rst, frame_count, late_count
    );
endinterface

// File: rtl/frame_scheduler.sv
// Paces framebuffer swaps to divided vblank ticks, counts late frames and runs
// the lose -> hold -> button -> game reset restart sequence.
module frame_scheduler #(
    parameter int FRAME_DIV       = 2,
    parameter int LOSE_HOLD_TICKS = 60,
    parameter int GAME_RST_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    frame_scheduler_if.slave   bus
);
    localparam int VB_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int HOLD_W  = (LOSE_HOLD_TICKS > 1) ? $clog2(LOSE_HOLD_TICKS) : 1;
    localparam int PULSE_W = (GAME_RST_CYCLES > 1) ? $clog2(GAME_RST_CYCLES) : 1;
    localparam logic [VB_W-1:0]    VB_LAST    = VB_W'(FRAME_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LOSE_HOLD_TICKS - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(GAME_RST_CYCLES - 1);

    typedef enum logic [1:0] {M_RENDER, M_WAIT_VBLANK, M_SWAP} main_state_t;
    typedef enum logic [1:0] {R_PLAY, R_LOST_HOLD, R_LOST_ARMED, R_RESET_PULSE} restart_state_t;

    logic [VB_W-1:0]    vb_cnt_reg;
    logic               tick;

    main_state_t        main_state_reg, main_state_next;
    logic               guard_reg, guard_next;
    logic               swap_reg, swap_next;
    logic               front_buf_reg, front_buf_next;
    logic [15:0]        frame_count_reg, frame_count_next;
    logic [7:0]         late_count_reg, late_count_next;

    restart_state_t     restart_state_reg, restart_state_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [PULSE_W-1:0] pulse_cnt_reg, pulse_cnt_next;
    logic               game_rst_reg, game_rst_next;
    logic               btn_q_reg;

    // The vblank divider never stops, so pacing survives a game restart.
    assign tick = bus.vblank_start && (vb_cnt_reg == VB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            vb_cnt_reg <= '0;
            btn_q_reg  <= 1'b0;
        end else begin
            btn_q_reg <= bus.btn;
            if (bus.vblank_start)
                vb_cnt_reg <= (vb_cnt_reg == VB_LAST) ? '0 : vb_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_state_reg  <= M_RENDER;
            guard_reg       <= 1'b1;
            swap_reg        <= 1'b0;
            front_buf_reg   <= 1'b0;
            frame_count_reg <= '0;
            late_count_reg  <= '0;
        end else begin
            main_state_reg  <= main_state_next;
            guard_reg       <= guard_next;
            swap_reg        <= swap_next;
            front_buf_reg   <= front_buf_next;
            frame_count_reg <= frame_count_next;
            late_count_reg  <= late_count_next;
        end
    end

    // swap_next is asserted only on entry to M_SWAP, so the pulse lines up with that state.
    always_comb begin
        main_state_next  = main_state_reg;
        guard_next       = guard_reg;
        swap_next        = 1'b0;
        front_buf_next   = front_buf_reg;
        frame_count_next = frame_count_reg;
        late_count_next  = late_count_reg;
        if (game_rst_reg) begin
            main_state_next  = M_RENDER;
            guard_next       = 1'b1;
            frame_count_next = '0;
        end else begin
            case (main_state_reg)
                M_RENDER: begin
                    if (tick && (late_count_reg != 8'hFF))
                        late_count_next = late_count_reg + 8'd1;
                    if (guard_reg)
                        guard_next = 1'b0;
                    else if (bus.render_done)
                        main_state_next = M_WAIT_VBLANK;
                end
                M_WAIT_VBLANK: begin
                    if (tick) begin
                        main_state_next  = M_SWAP;
                        swap_next        = 1'b1;
                        front_buf_next   = ~front_buf_reg;
                        frame_count_next = frame_count_reg + 16'd1;
                    end
                end
                M_SWAP: begin
                    main_state_next = M_RENDER;
                    guard_next      = 1'b1;
                end
                default: begin
                    main_state_next = M_RENDER;
                    guard_next      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            restart_state_reg <= R_PLAY;
            hold_cnt_reg      <= '0;
            pulse_cnt_reg     <= '0;
            game_rst_reg      <= 1'b0;
        end else begin
            restart_state_reg <= restart_state_next;
            hold_cnt_reg      <= hold_cnt_next;
            pulse_cnt_reg     <= pulse_cnt_next;
            game_rst_reg      <= game_rst_next;
        end
    end

    always_comb begin
        restart_state_next = restart_state_reg;
        hold_cnt_next      = hold_cnt_reg;
        pulse_cnt_next     = pulse_cnt_reg;
        game_rst_next      = game_rst_reg;
        case (restart_state_reg)
            R_PLAY: begin
                if (bus.lose) begin
                    restart_state_next = R_LOST_HOLD;
                    hold_cnt_next      = '0;
                end
            end
            R_LOST_HOLD: begin
                if (tick) begin
                    if (hold_cnt_reg == HOLD_LAST)
                        restart_state_next = R_LOST_ARMED;
                    else
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            R_LOST_ARMED: begin
                if (bus.btn && !btn_q_reg) begin
                    restart_state_next = R_RESET_PULSE;
                    pulse_cnt_next     = '0;
                    game_rst_next      = 1'b1;
                end
            end
            R_RESET_PULSE: begin
                if (pulse_cnt_reg == PULSE_LAST) begin
                    restart_state_next = R_PLAY;
                    game_rst_next      = 1'b0;
                end else begin
                    pulse_cnt_next = pulse_cnt_reg + 1'b1;
                end
            end
            default: begin
                restart_state_next = R_PLAY;
                game_rst_next      = 1'b0;
            end
        endcase
    end

    assign bus.swap        = swap_reg;
    assign bus.front_buf   = front_buf_reg;
    assign bus.game_rst    = game_rst_reg;
    assign bus.frame_count = frame_count_reg;
    assign bus.late_count  = late_count_reg;
endmodule
